// File: rtl/led_display_scheduler.sv
// Display source arbiter for the 8-digit seven-segment panel: picks display_op from CPU override,
// auto rotation or switches, and serves raw hex or BCD via one shared iterative double-dabble engine.
module led_display_scheduler #(
  parameter int TICK_DIV    = 100_000,
  parameter int DWELL_TICKS = 2000,
  parameter int HOLD_TICKS  = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic        auto_mode,
  input  logic [2:0]  sw_op,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] bubble_num,
  input  logic [31:0] ram_display_data_out,
  output logic [2:0]  display_op,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic        bcd_busy,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] presc_q, dwell_q, hold_cnt_q, cpu_val_q;
  logic        en_q, auto_q, tick, cpu_edge, op_chg;
  logic [2:0]  rot_q, sel;
  logic [31:0] raw_src, bin_src, snap_q, bcd_q, bcd_adj;
  logic [4:0]  cnt_q;
  logic        ovf_q;

  assign tick     = (presc_q == 32'(TICK_DIV - 1));
  assign cpu_edge = led_cpu_enable & ~en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      cpu_hold   <= 1'b0;
      hold_cnt_q <= '0;
      cpu_val_q  <= '0;
      rot_q      <= 3'b001;
      dwell_q    <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 32'd1;
      en_q    <= led_cpu_enable;
      auto_q  <= auto_mode;
      // A fresh CPU strobe beats a hold expiring on the same tick.
      if (cpu_edge) begin
        cpu_hold   <= 1'b1;
        hold_cnt_q <= '0;
        cpu_val_q  <= led_data_in;
      end else if (cpu_hold && tick) begin
        if (hold_cnt_q == 32'(HOLD_TICKS - 1)) begin
          cpu_hold   <= 1'b0;
          hold_cnt_q <= '0;
        end else begin
          hold_cnt_q <= hold_cnt_q + 32'd1;
        end
      end
      if (auto_mode && !auto_q) begin
        rot_q   <= 3'b001;
        dwell_q <= '0;
      end else if (auto_mode && !cpu_hold && tick) begin
        if (dwell_q == 32'(DWELL_TICKS - 1)) begin
          dwell_q <= '0;
          case (rot_q)
            3'b001:  rot_q <= 3'b011;
            3'b011:  rot_q <= 3'b111;
            3'b111:  rot_q <= 3'b101;
            3'b101:  rot_q <= 3'b010;
            default: rot_q <= 3'b001;
          endcase
        end else begin
          dwell_q <= dwell_q + 32'd1;
        end
      end
    end
  end

  always_comb begin
    sel = sw_op;
    if (cpu_hold)       sel = 3'b000;
    else if (auto_mode) sel = rot_q;
  end

  assign op_chg = (sel != display_op);

  always_comb begin
    raw_src = '0;
    bin_src = '0;
    case (display_op)
      3'b000:  raw_src = cpu_val_q;
      3'b010:  raw_src = ram_display_data_out;
      3'b001:  bin_src = total_cycles;
      3'b011:  bin_src = uncondi_branch_num;
      3'b111:  bin_src = condi_branch_num;
      3'b101:  bin_src = bubble_num;
      default: raw_src = '0;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Every op with bit 0 set is a statistics counter needing BCD conversion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!op_chg && display_op[0]) state_d = S_LOAD;
      S_LOAD:  state_d = op_chg ? S_IDLE : S_SHIFT;
      S_SHIFT: if (op_chg) state_d = S_IDLE;
               else if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign bcd_busy = (state_q == S_LOAD) || (state_q == S_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_op <= 3'b000;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      snap_q     <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      display_op <= sel;
      if (op_chg) begin
        disp_valid <= 1'b0;
      end else if (!display_op[0]) begin
        disp_data  <= raw_src;
        disp_valid <= 1'b1;
      end else begin
        case (state_q)
          S_LOAD: begin
            snap_q <= bin_src;
            bcd_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= (bin_src > 32'd99_999_999);
          end
          S_SHIFT: begin
            bcd_q  <= {bcd_adj[30:0], snap_q[31]};
            snap_q <= {snap_q[30:0], 1'b0};
            cnt_q  <= cnt_q + 5'd1;
          end
          S_DONE: begin
            disp_data  <= ovf_q ? 32'h9999_9999 : bcd_q;
            disp_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_display_scheduler.sv
// Bench for led_display_scheduler: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a cycle-level behavioural model.
module tb_led_display_scheduler;
  localparam int TD = 4, DW = 2, HT = 3;
  localparam logic [2:0] ROT [5] = '{3'd1, 3'd3, 3'd7, 3'd5, 3'd2};

  logic clk = 0, rst_n = 0;
  logic led_cpu_enable = 0, auto_mode = 0;
  logic [31:0] led_data_in = 0, total_cycles = 0, uncondi_branch_num = 0, condi_branch_num = 0;
  logic [31:0] bubble_num = 0, ram_display_data_out = 0;
  logic [2:0]  sw_op = 0;
  logic [2:0]  display_op;
  logic [31:0] disp_data;
  logic        disp_valid, bcd_busy, cpu_hold;

  led_display_scheduler #(.TICK_DIV(TD), .DWELL_TICKS(DW), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst_n(rst_n), .led_cpu_enable(led_cpu_enable), .led_data_in(led_data_in),
    .auto_mode(auto_mode), .sw_op(sw_op), .total_cycles(total_cycles),
    .uncondi_branch_num(uncondi_branch_num), .condi_branch_num(condi_branch_num),
    .bubble_num(bubble_num), .ram_display_data_out(ram_display_data_out),
    .display_op(display_op), .disp_data(disp_data), .disp_valid(disp_valid),
    .bcd_busy(bcd_busy), .cpu_hold(cpu_hold));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_print = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  int          m_presc, m_ht, m_pos, m_dwell, m_s;
  bit          m_hold, m_en_q, m_auto_q, m_valid;
  logic [2:0]  m_op;
  logic [31:0] m_disp, m_cpu, m_snap;

  function automatic bit is_stat(input logic [2:0] op);
    return op inside {3'd1, 3'd3, 3'd7, 3'd5};
  endfunction

  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] r;
    longint unsigned x;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = 0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] stat_src(input logic [2:0] op);
    case (op)
      3'd1: return total_cycles;
      3'd3: return uncondi_branch_num;
      3'd7: return condi_branch_num;
      3'd5: return bubble_num;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] raw_val(input logic [2:0] op);
    if (op == 3'd0) return m_cpu;
    if (op == 3'd2) return ram_display_data_out;
    return 0;
  endfunction

  // One conversion every 35 clks after a selection settles: snapshot 2 clks in, result at 35.
  wire m_busy = is_stat(m_op) && (m_s % 35 >= 1) && (m_s % 35 <= 33);

  always @(posedge clk or negedge rst_n) begin : model
    bit tick;
    logic [2:0] sel;
    int ns;
    if (!rst_n) begin
      m_presc <= 0; m_ht <= 0; m_pos <= 0; m_dwell <= 0; m_s <= 0;
      m_hold <= 0; m_en_q <= 0; m_auto_q <= 0; m_valid <= 0;
      m_op <= 0; m_disp <= 0; m_cpu <= 0; m_snap <= 0;
    end else begin
      tick = (m_presc == TD - 1);
      sel  = m_hold ? 3'd0 : (auto_mode ? ROT[m_pos] : sw_op);
      ns   = m_s + 1;
      m_presc  <= tick ? 0 : m_presc + 1;
      m_en_q   <= led_cpu_enable;
      m_auto_q <= auto_mode;
      if (led_cpu_enable && !m_en_q) begin
        m_hold <= 1; m_ht <= 0; m_cpu <= led_data_in;
      end else if (m_hold && tick) begin
        if (m_ht + 1 == HT) m_hold <= 0;
        m_ht <= m_ht + 1;
      end
      if (auto_mode && !m_auto_q) begin
        m_pos <= 0; m_dwell <= 0;
      end else if (auto_mode && !m_hold && tick) begin
        if (m_dwell + 1 == DW) begin m_pos <= (m_pos + 1) % 5; m_dwell <= 0; end
        else m_dwell <= m_dwell + 1;
      end
      if (sel != m_op) begin
        m_op <= sel; m_valid <= 0; m_s <= 0;
      end else begin
        m_s <= ns;
        if (!is_stat(m_op)) begin
          m_disp <= raw_val(m_op); m_valid <= 1;
        end else begin
          if (ns % 35 == 2) m_snap <= stat_src(m_op);
          if (ns % 35 == 0) begin m_disp <= to_bcd(m_snap); m_valid <= 1; end
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    n_cmp++;
    if (display_op !== m_op || disp_data !== m_disp || disp_valid !== m_valid ||
        bcd_busy !== m_busy || cpu_hold !== m_hold) begin
      n_bad++;
      if (n_print < 30) begin
        n_print++;
        $display("FAIL model_cycle t=%0t: got op=%0d data=%h valid=%b busy=%b hold=%b, expected op=%0d data=%h valid=%b busy=%b hold=%b",
                 $time, display_op, disp_data, disp_valid, bcd_busy, cpu_hold,
                 m_op, m_disp, m_valid, m_busy, m_hold);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return $urandom_range(0, 999);
      1: return 32'd99_999_999;
      2: return 32'd100_000_000;
      3: return $urandom;
      default: return $urandom_range(0, 99_999_999);
    endcase
  endfunction

  logic [2:0]  seen [$];
  int          seen_t [$];
  logic [2:0]  last_op, frozen_op;
  logic [31:0] t2_in [4] = '{32'd0, 32'd99_999_999, 32'd100_000_000, 32'hFFFF_FFFF};
  logic [31:0] t2_ex [4] = '{32'h0, 32'h9999_9999, 32'h9999_9999, 32'h9999_9999};
  bit          saw42, ok;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("reset_op", {29'd0, display_op}, 32'd0);
    check("reset_data", disp_data, 32'd0);
    check("reset_flags", {29'd0, disp_valid, bcd_busy, cpu_hold}, 32'd0);

    // 1: first BCD conversion after reset
    sw_op = 3'd1; total_cycles = 32'd12_345_678;
    rst_n = 1;
    repeat (36) @(negedge clk);
    check("t1_op", {29'd0, display_op}, 32'd1);
    check("t1_data", disp_data, 32'h1234_5678);
    check("t1_valid", {31'd0, disp_valid}, 32'd1);

    // 2: boundary values and saturation
    for (int i = 0; i < 4; i++) begin
      total_cycles = t2_in[i];
      repeat (72) @(negedge clk);
      check($sformatf("t2_bcd_%0d", i), disp_data, t2_ex[i]);
    end

    // 3: CPU override over the RAM viewer
    sw_op = 3'd2; ram_display_data_out = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("t3_ram", disp_data, 32'hDEAD_BEEF);
    led_cpu_enable = 1; led_data_in = 32'hCAFE_0042;
    @(negedge clk);
    led_cpu_enable = 0; led_data_in = 32'h1111_1111;
    repeat (2) @(negedge clk);
    check("t3_cpu_op", {29'd0, display_op}, 32'd0);
    check("t3_cpu_data", disp_data, 32'hCAFE_0042);
    check("t3_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (20) @(negedge clk);
    check("t3_back_op", {29'd0, display_op}, 32'd2);
    check("t3_back_data", disp_data, 32'hDEAD_BEEF);

    // 4: auto rotation every DW*TD clks
    auto_mode = 1;
    last_op = display_op;
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (display_op != last_op) begin
        seen.push_back(display_op); seen_t.push_back(c); last_op = display_op;
      end
    end
    check("t4_count", 32'(seen.size()), 32'd6);
    if (seen.size() >= 6) begin
      check("t4_seq", {8'd0, seen[0], seen[1], seen[2], seen[3], seen[4], seen[5], 6'd0},
            {8'd0, 3'd1, 3'd3, 3'd7, 3'd5, 3'd2, 3'd1, 6'd0});
      check("t4_period", 32'(seen_t[3] - seen_t[2]), 32'd8);
    end
    last_op = display_op; ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (display_op != last_op) ok = 1;
    end
    frozen_op = display_op;
    led_cpu_enable = 1; led_data_in = 32'h0000_0034;
    @(negedge clk);
    led_cpu_enable = 0;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (!cpu_hold && display_op != 3'd0) ok = 1;
    end
    check("t4_resume_seen", {31'd0, ok}, 32'd1);
    check("t4_resume_op", {29'd0, display_op}, {29'd0, frozen_op});

    // 5: abort mid-SHIFT
    auto_mode = 0; sw_op = 3'd2; ram_display_data_out = 32'h0BAD_F00D;
    repeat (4) @(negedge clk);
    total_cycles = 32'd42; uncondi_branch_num = 32'd7; sw_op = 3'd1;
    repeat (12) @(negedge clk);
    check("t5_busy", {31'd0, bcd_busy}, 32'd1);
    sw_op = 3'd3;
    @(negedge clk);
    check("t5_valid_drop", {31'd0, disp_valid}, 32'd0);
    saw42 = 0; ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (disp_data == 32'h42) saw42 = 1;
      if (disp_valid) ok = 1;
    end
    check("t5_no_partial", {31'd0, saw42}, 32'd0);
    check("t5_valid_rise", {31'd0, ok}, 32'd1);
    check("t5_data", disp_data, 32'h0000_0007);

    // 6: asynchronous reset mid-SHIFT
    sw_op = 3'd1; total_cycles = 32'd31_415_926;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("t6_async_op", {29'd0, display_op}, 32'd0);
    check("t6_async_data", disp_data, 32'd0);
    check("t6_async_flags", {29'd0, disp_valid, bcd_busy, cpu_hold}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (37) @(negedge clk);
    check("t6_restart", disp_data, 32'h3141_5926);

    // random phase
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) sw_op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) auto_mode = ~auto_mode;
      led_cpu_enable = ($urandom_range(0, 119) == 0);
      led_data_in = $urandom;
      ram_display_data_out = $urandom;
      if ($urandom_range(0, 9) == 0) total_cycles = rnd_val();
      if ($urandom_range(0, 9) == 0) uncondi_branch_num = rnd_val();
      if ($urandom_range(0, 9) == 0) condi_branch_num = rnd_val();
      if ($urandom_range(0, 9) == 0) bubble_num = rnd_val();
    end

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
